tt_um_hoene_manchester_tx_sequencer: RTL and testbench

TT_UM_HOENE_MANCHESTER_TX_SEQUENCER -- requirements
Module: tt_um_hoene_manchester_tx_sequencer

---
 rtl/tt_um_hoene_led_pkg.sv | 18 +
 rtl/tt_um_hoene_bit_timer.sv | 48 ++++
 rtl/tt_um_hoene_manchester_tx_sequencer.sv | 171 +++++++++++++++++
 tb/tb_tt_um_hoene_manchester_tx_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_um_hoene_led_pkg.sv
// Shared definitions for the LED frame transmitter: sequencer state
// encodings and the smallest bit period the Manchester encoder can accept.
package tt_um_hoene_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

    // A bit period below this cannot hold two Manchester half-bits.
    localparam logic [5:0] MIN_PULSEWIDTH = 6'd4;

    function automatic logic pulsewidth_ok(input logic [5:0] pw);
        return pw >= MIN_PULSEWIDTH;
    endfunction

endpackage

// File: rtl/tt_um_hoene_bit_timer.sv
// Bit-period timer: latches the period P on load and raises tick_o for one
// cycle every P cycles while enabled. The counter is cleared when idle.
module tt_um_hoene_bit_timer
    import tt_um_hoene_led_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic       en_i,
    input  logic [5:0] period_i,
    output logic       tick_o
);

    logic [5:0] period_q, period_d;
    logic [5:0] cnt_q, cnt_d;

    // Next-state: reload on load or on expiry, count down otherwise.
    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            period_d = period_i;
            cnt_d    = period_i - 6'd1;
        end else if (en_i) begin
            if (cnt_q == 6'd0) begin
                cnt_d = period_q - 6'd1;
            end else begin
                cnt_d = cnt_q - 6'd1;
            end
        end else begin
            cnt_d = 6'd0;
        end
    end

    // Period and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 6'd0;
            cnt_q    <= 6'd0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
        end
    end

    assign tick_o = en_i && !load_i && (cnt_q == 6'd0);

endmodule

// File: rtl/tt_um_hoene_manchester_tx_sequencer.sv
// Frame sequencer for the Manchester LED transmitter. Accepts a WIDTH-bit
// word, strobes its bits MSB first to the encoder every P clocks, then
// idles for GAP_CYCLES clocks and pulses done.
// Optional feature: define TX_PARITY_EN to append an even-parity bit as an
// extra strobe after the payload.
module tt_um_hoene_manchester_tx_sequencer
    import tt_um_hoene_led_pkg::*;
#(
    parameter int WIDTH      = 24,
    parameter int GAP_CYCLES = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    input  logic [5:0]       in_pulsewidth,
    input  logic             abort,
    output logic             bit_data,
    output logic             bit_clk,
    output logic             bit_error,
    output logic             busy,
    output logic             done
);

`ifdef TX_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif

    localparam logic [4:0] BIT_LAST = 5'(NBITS - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    tx_state_e        state_q, state_d;
    logic [NBITS-1:0] sr_q, sr_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       gap_cnt_q, gap_cnt_d;
    logic             bit_data_q, bit_data_d;
    logic             bit_clk_q, bit_clk_d;
    logic             bit_error_q, bit_error_d;
    logic             done_q, done_d;

    logic             timer_load;
    logic             timer_tick;
    logic [NBITS-1:0] load_word;

`ifdef TX_PARITY_EN
    assign load_word = {in_word, ^in_word};
`else
    assign load_word = in_word;
`endif

    // Held low during reset so no upstream word is offered into a
    // sequencer that is being cleared.
    assign in_ready = rst_n && (state_q == ST_IDLE) && !abort;
    assign busy     = (state_q != ST_IDLE);

    tt_um_hoene_bit_timer u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (timer_load),
        .en_i     (state_q == ST_SHIFT),
        .period_i (in_pulsewidth),
        .tick_o   (timer_tick)
    );

    // Sequencer next-state and registered-output logic.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        bit_data_d  = bit_data_q;
        bit_clk_d   = 1'b0;
        bit_error_d = 1'b0;
        done_d      = 1'b0;
        timer_load  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    if (!pulsewidth_ok(in_pulsewidth)) begin
                        bit_error_d = 1'b1;
                    end else begin
                        state_d    = ST_SHIFT;
                        sr_d       = load_word;
                        bit_data_d = load_word[NBITS-1];
                        bit_clk_d  = 1'b1;
                        bit_cnt_d  = BIT_LAST;
                        timer_load = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    sr_d        = '0;
                    bit_data_d  = 1'b0;
                    bit_cnt_d   = 5'd0;
                    bit_error_d = 1'b1;
                end else if (timer_tick) begin
                    if (bit_cnt_q == 5'd0) begin
                        state_d    = ST_GAP;
                        bit_data_d = 1'b0;
                        gap_cnt_d  = GAP_LAST;
                    end else begin
                        bit_cnt_d  = bit_cnt_q - 5'd1;
                        sr_d       = {sr_q[NBITS-2:0], 1'b0};
                        bit_data_d = sr_q[NBITS-2];
                        bit_clk_d  = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    sr_d        = '0;
                    bit_data_d  = 1'b0;
                    gap_cnt_d   = 8'd0;
                    bit_error_d = 1'b1;
                end else if (gap_cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift register is reset along with control state so a
        // frame cut off by reset leaves no stale payload behind.
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= 5'd0;
            gap_cnt_q   <= 8'd0;
            bit_data_q  <= 1'b0;
            bit_clk_q   <= 1'b0;
            bit_error_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_data_q  <= bit_data_d;
            bit_clk_q   <= bit_clk_d;
            bit_error_q <= bit_error_d;
            done_q      <= done_d;
        end
    end

    assign bit_data  = bit_data_q;
    assign bit_clk   = bit_clk_q;
    assign bit_error = bit_error_q;
    assign done      = done_q;

endmodule

// File: tb/tb_tt_um_hoene_manchester_tx_sequencer.sv
// Scoreboard bench for the Manchester TX sequencer. Stimulus pushes the
// expected strobe, done and bit_error events (with their cycle numbers);
// a negedge monitor pops and compares each event the DUT produces.
module tb_tt_um_hoene_manchester_tx_sequencer;

    localparam int WIDTH = 24;
    localparam int GAP   = 64;
`ifdef TX_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    typedef struct {
        int   cyc;
        logic data;
    } strobe_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_word = '0;
    logic [5:0]       in_pulsewidth = 6'd0;
    logic             abort = 1'b0;
    logic             in_ready;
    logic             bit_data;
    logic             bit_clk;
    logic             bit_error;
    logic             busy;
    logic             done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    strobe_t exp_q[$];
    int      done_q[$];
    int      err_q[$];

    tt_um_hoene_manchester_tx_sequencer #(
        .WIDTH      (WIDTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_word       (in_word),
        .in_ready      (in_ready),
        .in_pulsewidth (in_pulsewidth),
        .abort         (abort),
        .bit_data      (bit_data),
        .bit_clk       (bit_clk),
        .bit_error     (bit_error),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s: got event at cycle %0d, want none", name, cyc);
    endtask

    // Expected events for a frame whose inputs were driven in cycle k.
    task automatic push_frame(input int k, input logic [WIDTH-1:0] word, input int p,
                              input int n, input bit with_done);
        logic [NB-1:0] bits;
        strobe_t       e;
`ifdef TX_PARITY_EN
        bits = {word, ^word};
`else
        bits = word;
`endif
        for (int i = 0; i < n; i++) begin
            e.cyc  = k + 1 + i * p;
            e.data = bits[NB-1-i];
            exp_q.push_back(e);
        end
        if (with_done) done_q.push_back(k + 1 + NB * p + GAP);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic offer(input logic [WIDTH-1:0] w, input logic [5:0] p, output int k);
        wait_ready();
        in_word       = w;
        in_pulsewidth = p;
        in_valid      = 1'b1;
        k             = cyc;
    endtask

    // Monitor: every strobe, done and error pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_clk) begin
                if (exp_q.size() == 0) begin
                    unexpected("strobe_unexpected");
                end else begin
                    strobe_t e;
                    e = exp_q.pop_front();
                    check("strobe_cycle", cyc, e.cyc);
                    check("strobe_data", {31'd0, bit_data}, {31'd0, e.data});
                end
            end
            if (done) begin
                if (done_q.size() == 0) unexpected("done_unexpected");
                else check("done_cycle", cyc, done_q.pop_front());
            end
            if (bit_error) begin
                if (err_q.size() == 0) unexpected("error_unexpected");
                else check("error_cycle", cyc, err_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int s;
        int d1;
        int k2;

        // Reset state.
        repeat (3) @(negedge clk);
        #1;
        check("rst_bit_clk", {31'd0, bit_clk}, 32'd0);
        check("rst_bit_data", {31'd0, bit_data}, 32'd0);
        check("rst_bit_error", {31'd0, bit_error}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Nominal frame: 0xA5F00F at P=10.
        offer(24'hA5F00F, 6'd10, k);
        push_frame(k, 24'hA5F00F, 10, NB, 1'b1);
        @(posedge clk);
        #1;
        in_valid      = 1'b0;
        in_pulsewidth = 6'd3;
        check("nominal_busy", {31'd0, busy}, 32'd1);
        check("nominal_not_ready", {31'd0, in_ready}, 32'd0);
        wait_cyc(k + 1 + NB * 10 + GAP + 2);
        check("nominal_idle_busy", {31'd0, busy}, 32'd0);

        // Bad pulse width: one error pulse, no strobe, stays ready.
        offer(24'h123456, 6'd3, k);
        err_q.push_back(k + 1);
        check("badpw_ready_offer", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("badpw_ready_after", {31'd0, in_ready}, 32'd1);
        check("badpw_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // Abort has priority over in_valid in IDLE.
        in_pulsewidth = 6'd10;
        in_valid      = 1'b1;
        abort         = 1'b1;
        #1;
        check("abort_idle_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        abort    = 1'b0;
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        repeat (20) @(posedge clk);
        #1;

        // Abort at strobe 5 of a P=8 frame.
        offer(24'h3C5A96, 6'd8, k);
        push_frame(k, 24'h3C5A96, 8, 5, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s = k + 1 + 4 * 8;
        wait_cyc(s);
        abort = 1'b1;
        err_q.push_back(s + 1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy_cleared", {31'd0, busy}, 32'd0);
        wait_cyc(s + 2);
        check("abort_ready_2cyc", {31'd0, in_ready}, 32'd1);
        repeat (300) @(posedge clk);
        #1;

        // Back-to-back frames with in_valid held; P changed mid-frame.
        offer(24'hF0F0F0, 6'd5, k);
        push_frame(k, 24'hF0F0F0, 5, NB, 1'b1);
        @(posedge clk);
        #1;
        in_word       = 24'h0FF00F;
        in_pulsewidth = 6'd6;
        d1 = k + 1 + NB * 5 + GAP;
        k2 = d1;
        push_frame(k2, 24'h0FF00F, 6, NB, 1'b1);
        wait_cyc(d1 + 1);
        in_valid = 1'b0;
        check("b2b_second_busy", {31'd0, busy}, 32'd1);
        wait_cyc(k2 + 1 + NB * 6 + GAP + 2);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);

        // Reset at strobe 12 of a P=10 frame.
        offer(24'hA5F00F, 6'd10, k);
        push_frame(k, 24'hA5F00F, 10, 12, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        s = k + 1 + 11 * 10;
        wait_cyc(s);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_bit_clk", {31'd0, bit_clk}, 32'd0);
        check("midrst_bit_data", {31'd0, bit_data}, 32'd0);
        check("midrst_bit_error", {31'd0, bit_error}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_release_busy", {31'd0, busy}, 32'd0);
        check("midrst_release_ready", {31'd0, in_ready}, 32'd1);
        repeat (150) @(posedge clk);
        #1;

`ifdef TX_PARITY_EN
        // Parity: 0x000001 ends with a 1, 0x000003 ends with a 0.
        offer(24'h000001, 6'd4, k);
        push_frame(k, 24'h000001, 4, NB, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cyc(k + 1 + NB * 4 + GAP + 2);
        offer(24'h000003, 6'd4, k);
        push_frame(k, 24'h000003, 4, NB, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_cyc(k + 1 + NB * 4 + GAP + 2);
`endif

        repeat (20) @(posedge clk);
        #1;
        check("pending_strobes", exp_q.size(), 32'd0);
        check("pending_done", done_q.size(), 32'd0);
        check("pending_errors", err_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
